uart_rx_to_between: RTL and testbench

UART_RX_TO_BETWEEN -- requirements
Module: uart_rx_to_between

---
 rtl/uart_rx_to_between_pkg.sv | 17 +
 rtl/uart_rx_to_between_rx_sync.sv | 25 ++
 rtl/uart_rx_to_between.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_to_between.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_to_between_pkg.sv
// Shared UART receive definitions: FSM state encodings and default bit period.
// Reusable by the transmit side (Out_to_com) so both agree on encodings.
package uart_rx_to_between_pkg;

   localparam int DEF_CLKS_PER_BIT = 16;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] PARITY    = 3'd3;
   localparam logic [2:0] STOP      = 3'd4;

   localparam logic [1:0] H_IDLE    = 2'd0;
   localparam logic [1:0] H_SENT    = 2'd1;
   localparam logic [1:0] H_RELEASE = 2'd2;

endpackage

// File: rtl/uart_rx_to_between_rx_sync.sv
// Two-flop synchronizer for the asynchronous UART rx line; 2 clk latency.
// Resets to the idle-high line level so no false start bit appears after reset.
module rx_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_rx,
   output logic o_rx
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_rx;
         r_sync <= r_meta;
      end
   end

   assign o_rx = r_sync;

endmodule

// File: rtl/uart_rx_to_between.sv
// UART 8N1 receiver feeding a four-phase tsent/trecieve handshake; tsent rises 2 clk after stop sample.
// Define RX_PARITY_EN for 8E1 frames with a parity_err flag. A byte arriving while one is held is dropped (overrun).
module uart_rx_to_between
   import uart_rx_to_between_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] tdata,
   output logic       tsent,
   input  logic       trecieve,
   output logic       frame_err,
   output logic       overrun
`ifdef RX_PARITY_EN
  ,output logic       parity_err
`endif
);

   localparam logic [11:0] HALF_CNT = 12'(CLKS_PER_BIT / 2 - 1);
   localparam logic [11:0] FULL_CNT = 12'(CLKS_PER_BIT - 1);

   logic       w_rx;
   logic       w_half;
   logic       w_full;
   logic       w_hold_clr;

   logic [2:0]  r_state;
   logic [11:0] r_timer;
   logic [2:0]  r_bitcnt;
   logic [7:0]  r_shift;
   logic        r_rx_prev;
   logic        r_done;
   logic        r_frame_err;
   logic [7:0]  r_hold;
   logic        r_hold_full;
   logic        r_overrun;
   logic [1:0]  r_hs;
   logic [7:0]  r_tdata;
   logic        r_tsent;
`ifdef RX_PARITY_EN
   logic        r_par_bad;
   logic        r_parity_err;
`endif

   rx_sync u_rx_sync (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_rx    (rx),
      .o_rx    (w_rx)
   );

   assign w_half = (r_timer == HALF_CNT);
   assign w_full = (r_timer == FULL_CNT);

   // Receive FSM; r_done is a one-cycle pulse marking a clean, accepted frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_timer     <= 12'd0;
         r_bitcnt    <= 3'd0;
         r_shift     <= 8'h00;
         r_rx_prev   <= 1'b1;
         r_done      <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef RX_PARITY_EN
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_rx_prev <= w_rx;
         r_done    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_rx_prev && !w_rx) begin
                  r_state <= START;
                  r_timer <= 12'd0;
               end
            end
            START: begin
               if (w_half) begin
                  r_timer  <= 12'd0;
                  r_bitcnt <= 3'd0;
                  r_state  <= w_rx ? IDLE : DATA;
               end else begin
                  r_timer <= r_timer + 12'd1;
               end
            end
            DATA: begin
               if (w_full) begin
                  r_timer  <= 12'd0;
                  r_shift  <= {w_rx, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) begin
`ifdef RX_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                  end
               end else begin
                  r_timer <= r_timer + 12'd1;
               end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
               if (w_full) begin
                  r_timer   <= 12'd0;
                  r_state   <= STOP;
                  r_par_bad <= ^{r_shift, w_rx};
                  if (^{r_shift, w_rx}) r_parity_err <= 1'b1;
               end else begin
                  r_timer <= r_timer + 12'd1;
               end
            end
`endif
            STOP: begin
               if (w_full) begin
                  r_timer <= 12'd0;
                  r_state <= IDLE;
                  if (!w_rx) begin
                     r_frame_err <= 1'b1;
                  end else begin
`ifdef RX_PARITY_EN
                     r_done <= !r_par_bad;
`else
                     r_done <= 1'b1;
`endif
                  end
               end else begin
                  r_timer <= r_timer + 12'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // A release in the same cycle as a new byte frees the slot for that byte.
   assign w_hold_clr = (r_hs == H_SENT) && trecieve;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold      <= 8'h00;
         r_hold_full <= 1'b0;
         r_overrun   <= 1'b0;
      end else if (r_done) begin
         if (!r_hold_full || w_hold_clr) begin
            r_hold      <= r_shift;
            r_hold_full <= 1'b1;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (w_hold_clr) begin
         r_hold_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hs    <= H_IDLE;
         r_tdata <= 8'h00;
         r_tsent <= 1'b0;
      end else begin
         case (r_hs)
            H_IDLE: begin
               if (r_hold_full && !trecieve) begin
                  r_tdata <= r_hold;
                  r_tsent <= 1'b1;
                  r_hs    <= H_SENT;
               end
            end
            H_SENT: begin
               if (trecieve) begin
                  r_tsent <= 1'b0;
                  r_hs    <= H_RELEASE;
               end
            end
            H_RELEASE: begin
               if (!trecieve) r_hs <= H_IDLE;
            end
            default: begin
               r_tsent <= 1'b0;
               r_hs    <= H_IDLE;
            end
         endcase
      end
   end

   assign tdata     = r_tdata;
   assign tsent     = r_tsent;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
`ifdef RX_PARITY_EN
   assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_to_between.sv
// Bench for uart_rx_to_between: directed frames plus random traffic against a
// frame-level model (expected byte queue, one-slot holding state, sticky flags).
module tb_uart_rx_to_between;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx = 1'b1;
   logic       trecieve = 1'b0;
   logic [7:0] tdata;
   logic       tsent;
   logic       frame_err;
   logic       overrun;
`ifdef RX_PARITY_EN
   logic       parity_err;
   bit         exp_perr = 1'b0;
`endif

   uart_rx_to_between #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .tdata     (tdata),
      .tsent     (tsent),
      .trecieve  (trecieve),
      .frame_err (frame_err),
      .overrun   (overrun)
`ifdef RX_PARITY_EN
     ,.parity_err(parity_err)
`endif
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   int         n_rise = 0;
   int         t_start = 0;
   int         t_rise = 0;
   int         ack_dly = 3;
   bit         ack_en = 1'b1;
   bit         m_full = 1'b0;
   bit         exp_ferr = 1'b0;
   bit         exp_ovr = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_frame_err"}, frame_err, exp_ferr);
      check({tag, "_overrun"}, overrun, exp_ovr);
`ifdef RX_PARITY_EN
      check({tag, "_parity_err"}, parity_err, exp_perr);
`endif
   endtask

   task automatic check_queue(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0)
         check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
   endtask

   // Drives one frame starting at a negedge; the model is updated at mid-stop,
   // which is before the DUT can present (and the bench acknowledge) the byte.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
      t_start = cyc;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
`ifdef RX_PARITY_EN
      rx = (^b) ^ !par_ok;
      repeat (CPB) @(negedge clk);
`endif
      rx = stop_ok;
      repeat (CPB / 2) @(negedge clk);
`ifdef RX_PARITY_EN
      if (!par_ok) exp_perr = 1'b1;
`endif
      if (!stop_ok) exp_ferr = 1'b1;
      if (stop_ok && par_ok) begin
         if (m_full) exp_ovr = 1'b1;
         else begin
            exp_q.push_back(b);
            m_full = 1'b1;
         end
      end
      repeat (CPB - CPB / 2) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic glitch(input int len);
      rx = 1'b0;
      repeat (len) @(negedge clk);
      rx = 1'b1;
   endtask

   initial begin : rise_mon
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (tsent && !prev) begin
            n_rise++;
            got_q.push_back(tdata);
            t_rise = cyc;
         end
         prev = tsent;
      end
   end

   initial begin : ack_proc
      logic [7:0] d0;
      forever begin
         @(negedge clk);
         if (ack_en && tsent && !trecieve) begin
            d0 = tdata;
            repeat (ack_dly) @(negedge clk);
            check("tdata_stable", tdata, d0);
            trecieve = 1'b1;
            m_full = 1'b0;
            for (int i = 0; i < 50 && tsent; i++) @(negedge clk);
            check("tsent_drop", tsent, 0);
            trecieve = 1'b0;
         end
      end
   end

   initial begin : main
      int r0;
      int kind;
      logic [7:0] b;
      bit pok;

      repeat (3) @(negedge clk);
      check("rst_tdata", tdata, 8'h00);
      check("rst_tsent", tsent, 0);
      check_flags("rst");
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // Clean byte, ack after 3 clk, with first-byte latency from start-bit edge
      send_frame(8'hA5, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      check("latency", t_rise - t_start, 3 + CPB / 2 + 9 * CPB + 2);
      check("a5_pulses", n_rise, 1);
      check_flags("a5");
      check_queue("a5");

      r0 = n_rise;
      glitch(4);
      repeat (30) @(negedge clk);
      check("glitch_tsent", n_rise - r0, 0);
      check_flags("glitch");

      r0 = n_rise;
      send_frame(8'h3C, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      check("ferr_tsent", n_rise - r0, 0);
      check_flags("ferr");

      // Holding register full: second byte must be dropped
      ack_en = 1'b0;
      r0 = n_rise;
      send_frame(8'h11, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      send_frame(8'h22, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      check("ovr_tdata", tdata, exp_q[0]);
      check("ovr_tsent_held", tsent, 1);
      check_flags("ovr");
      ack_en = 1'b1;
      repeat (60) @(negedge clk);
      check("ovr_pulses", n_rise - r0, 1);
      check_queue("ovr");

      // Reset in the middle of the data bits of 8'hFF
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      m_full = 1'b0;
      exp_ferr = 1'b0;
      exp_ovr = 1'b0;
`ifdef RX_PARITY_EN
      exp_perr = 1'b0;
`endif
      got_q.delete();
      exp_q.delete();
      check("rstmid_tsent", tsent, 0);
      check("rstmid_tdata", tdata, 8'h00);
      check_flags("rstmid");
      reset = 1'b1;
      repeat (5) @(negedge clk);
      r0 = n_rise;
      send_frame(8'h5A, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      check("rstmid_pulses", n_rise - r0, 1);
      check_flags("after_rst");
      check_queue("after_rst");

`ifdef RX_PARITY_EN
      r0 = n_rise;
      send_frame(8'h07, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      check("par_bad_tsent", n_rise - r0, 0);
      check_flags("par_bad");
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      check_queue("par_ok");
`endif

      for (int k = 0; k < 24; k++) begin
         kind = $urandom_range(0, 9);
         ack_dly = $urandom_range(1, 5);
         b = 8'($urandom);
         pok = 1'b1;
`ifdef RX_PARITY_EN
         pok = ($urandom_range(0, 4) != 0);
`endif
         if (kind == 0) glitch($urandom_range(1, 6));
         else send_frame(b, kind != 1, pok);
         repeat (16 + $urandom_range(0, 20)) @(negedge clk);
         check_flags("rand");
      end
      check_queue("rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
